core2axi4l: RTL

Bridges an Ibex core-side memory port (req/gnt/rvalid protocol) onto an AXI4-Lite master port. It is the initiator-side counterpart of the DM-slave bridge: a core LSU or instruction fetch port drives it, and it issues single AXI4-Lite read or write transactions into the interconnect. At most one transaction is in flight, and every granted request produces exactly one `rvalid` pulse.

---
 rtl/core2axi4l.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/core2axi4l.sv
// core2axi4l: bridges an Ibex req/gnt/rvalid memory port onto an AXI4-Lite master, one transaction in flight.
// Optional feature macro CORE2AXI4L_ERR_EN: report SLVERR/DECERR responses on core_err_o.
module core2axi4l #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    // core side
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    // AXI4-Lite master side
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [2:0]  axi_awprot_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    output logic        axi_bready_o,
    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [2:0]  axi_arprot_o,
    input  logic        axi_arready_i,
    input  logic        axi_rvalid_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    output logic        axi_rready_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_s, w_done_s;
    logic        b_err_s, r_err_s;
    logic        unused_s;

`ifdef CORE2AXI4L_ERR_EN
    assign b_err_s = axi_bresp_i[1];
    assign r_err_s = axi_rresp_i[1];
`else
    assign b_err_s = 1'b0;
    assign r_err_s = 1'b0;
`endif
    assign unused_s = ^{core_addr_i[1:0], axi_bresp_i, axi_rresp_i};

    // aw_pend/w_pend are the valid registers themselves; each side is done once idle or handshaking
    assign aw_done_s = !awvalid_q || axi_awready_i;
    assign w_done_s  = !wvalid_q || axi_wready_i;

    assign core_gnt_o    = (state_q == IDLE) && core_req_i;
    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = rdata_q;
    assign core_err_o    = err_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awprot_o  = PROT;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_bready_o  = bready_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = araddr_q;
    assign axi_arprot_o  = PROT;
    assign axi_rready_o  = rready_q;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= 32'h0000_0000;
            araddr_q  <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'b0000;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    state_d = core_we_i ? WADDR : RADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WADDR: begin
                if (aw_done_s && w_done_s) begin
                    state_d = WRESP;
                end else begin
                    state_d = WADDR;
                end
            end
            WRESP: begin
                if (axi_bvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WRESP;
                end
            end
            RADDR: begin
                if (axi_arready_i) begin
                    state_d = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                if (axi_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; core_rvalid is a single-cycle pulse
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (core_req_i && core_we_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = {core_addr_i[31:2], 2'b00};
                    wdata_d   = core_wdata_i;
                    wstrb_d   = core_be_i;
                end else if (core_req_i) begin
                    arvalid_d = 1'b1;
                    araddr_d  = {core_addr_i[31:2], 2'b00};
                end else begin
                    arvalid_d = 1'b0;
                end
            end
            WADDR: begin
                if (axi_awready_i) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (axi_wready_i) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_s && w_done_s) begin
                    bready_d = 1'b1;
                end else begin
                    bready_d = 1'b0;
                end
            end
            WRESP: begin
                if (axi_bvalid_i) begin
                    bready_d = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0000_0000;
                    err_d    = b_err_s;
                end else begin
                    bready_d = 1'b1;
                end
            end
            RADDR: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            RDATA: begin
                if (axi_rvalid_i) begin
                    rready_d = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = axi_rdata_i;
                    err_d    = r_err_s;
                end else begin
                    rready_d = 1'b1;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

endmodule
